// File: rtl/sgf_normalizer_pkg.sv
// Shared definitions for the significand normalizer: FSM state encoding and
// the widest all-ones exponent constant that modules slice to their EWR.
package fpu_norm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_e;

    localparam logic [31:0] EXP_ONES_MAX = '1;

endpackage

// File: rtl/sgf_normalizer_if.sv
// Start/done handshake and data bundle between the add/sub stage, the
// normalizer and the rounding/packing stage.
interface sgf_normalizer_if #(
    parameter int SWR = 26,
    parameter int EWR = 8
);
    logic           start_i;
    logic           Add_Sub_op_i;
    logic [SWR-1:0] Sgf_i;
    logic           FSM_C_i;
    logic [EWR-1:0] Exp_i;
    logic [SWR-1:0] Sgf_norm_o;
    logic [EWR-1:0] Exp_norm_o;
    logic           busy_o;
    logic           done_o;
    logic           zero_o;
    logic           underflow_o;
    logic           overflow_o;

    modport master (
        output start_i, Add_Sub_op_i, Sgf_i, FSM_C_i, Exp_i,
        input  Sgf_norm_o, Exp_norm_o, busy_o, done_o, zero_o, underflow_o, overflow_o
    );

    modport slave (
        input  start_i, Add_Sub_op_i, Sgf_i, FSM_C_i, Exp_i,
        output Sgf_norm_o, Exp_norm_o, busy_o, done_o, zero_o, underflow_o, overflow_o
    );
endinterface

// File: rtl/sgf_normalizer.sv
// Iterative significand normalizer: one right shift on carry-out, otherwise one
// left shift per cycle with exponent decrement until the MSB is set.
module sgf_normalizer
    import fpu_norm_pkg::*;
#(
    parameter int SWR = 26,
    parameter int EWR = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sgf_normalizer_if.slave        bus
);

    localparam logic [EWR-1:0] EXP_ONES = EXP_ONES_MAX[EWR-1:0];

    norm_state_e    state_q;
    logic [SWR-1:0] sgf_q;
    logic [EWR-1:0] exp_q;
    logic           cy_q;
    logic           busy_q;
    logic           done_q;
    logic           zero_q;
    logic           underflow_q;
    logic           overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sgf_q       <= '0;
            exp_q       <= '0;
            cy_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_q      <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        sgf_q       <= bus.Sgf_i;
                        exp_q       <= bus.Exp_i;
                        cy_q        <= bus.FSM_C_i & ~bus.Add_Sub_op_i;
                        zero_q      <= 1'b0;
                        underflow_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (cy_q) begin
                        sgf_q <= {1'b1, sgf_q[SWR-1:1]};
                        cy_q  <= 1'b0;
                        // exp of all-ones-minus-one or all-ones both land on (and stay at) all-ones
                        if (exp_q >= EXP_ONES - 1'b1) begin
                            exp_q      <= EXP_ONES;
                            overflow_q <= 1'b1;
                        end else begin
                            exp_q <= exp_q + 1'b1;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (sgf_q == '0) begin
                        exp_q   <= '0;
                        zero_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (sgf_q[SWR-1]) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (exp_q == '0) begin
                        underflow_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        sgf_q <= {sgf_q[SWR-2:0], 1'b0};
                        exp_q <= exp_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Sgf_norm_o  = sgf_q;
    assign bus.Exp_norm_o  = exp_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.zero_o      = zero_q;
    assign bus.underflow_o = underflow_q;
    assign bus.overflow_o  = overflow_q;

endmodule
